// File: rtl/sram_stream_pkg.sv
// Shared types and constants for the SRAM stream reader and its output FIFO.
package sram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/sram_read_fifo.sv
// Four-entry first-word-fall-through FIFO holding captured SRAM rows plus their last flag.
module sram_read_fifo
    import sram_stream_pkg::*;
#(
    parameter int DW = 129,
    localparam int PtrW = $clog2(FIFO_DEPTH),
    localparam int CntW = PtrW + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            push_i,
    input  logic [DW-1:0]   push_data_i,
    input  logic            pop_i,
    output logic [DW-1:0]   head_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wrPtr_q;
    logic [PtrW-1:0] rdPtr_q;
    logic [CntW-1:0] count_q;
    logic            doPop;
    logic            doPush;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPop  = pop_i && (count_q != '0);
    assign doPush = push_i && ((count_q != CntW'(FIFO_DEPTH)) || doPop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= push_data_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(push_i && !doPush));
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/sram_stream_reader.sv
// Streams consecutive SRAM rows onto a valid/ready port, throttling reads by FIFO credit.
module sram_stream_reader
    import sram_stream_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int NUM_ROWS = 4096,
    localparam int AddressWidth = $clog2(NUM_ROWS),
    localparam int CountWidth = AddressWidth + 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [AddressWidth-1:0] start_addr,
    input  logic [CountWidth-1:0]   start_count,
    output logic                    REB,
    output logic [AddressWidth-1:0] AB,
    input  logic [WIDTH-1:0]        Q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic                    busy
);

    localparam int FifoCntW = $clog2(FIFO_DEPTH) + 1;
    localparam int CreditW  = FifoCntW + 1;

    state_e                  state_q;
    logic [AddressWidth-1:0] addr_q;
    logic [AddressWidth-1:0] AB_q;
    logic [CountWidth-1:0]   remaining_q;
    logic [1:0]              outstanding_q;
    logic                    REB_q;
    logic                    issueLast_q;
    logic                    capValid_q;
    logic                    capLast_q;

    logic [FifoCntW-1:0]     fifoCount;
    logic                    fifoEmpty;
    logic [WIDTH:0]          fifoHead;
    logic                    pop;
    logic [CreditW-1:0]      credit;
    logic                    canIssue;
    logic                    startAccept;
    logic                    issue_d;
    logic                    lastIssue_d;
    logic                    drainDone;

    function automatic logic [AddressWidth-1:0] incAddr(input logic [AddressWidth-1:0] a);
        return (a == AddressWidth'(NUM_ROWS - 1)) ? '0 : a + 1'b1;
    endfunction

    // Credit counts both buffered rows and reads still travelling through the SRAM.
    assign pop         = !fifoEmpty && out_ready;
    assign credit      = {1'b0, fifoCount} + CreditW'(outstanding_q);
    assign canIssue    = (remaining_q != '0) && (credit < CreditW'(FIFO_DEPTH));
    assign startAccept = (state_q == IDLE) && start_valid && (start_count != '0);
    assign issue_d     = startAccept || ((state_q == READ) && canIssue);
    assign lastIssue_d = startAccept ? (start_count == CountWidth'(1))
                                     : (remaining_q == CountWidth'(1));
    assign drainDone   = (outstanding_q == 2'd0) &&
                         ((fifoCount == '0) || ((fifoCount == FifoCntW'(1)) && pop));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            AB_q          <= '0;
            remaining_q   <= '0;
            outstanding_q <= 2'd0;
            REB_q         <= 1'b1;
            issueLast_q   <= 1'b0;
            capValid_q    <= 1'b0;
            capLast_q     <= 1'b0;
        end else begin
            REB_q         <= !issue_d;
            issueLast_q   <= issue_d && lastIssue_d;
            capValid_q    <= !REB_q;
            capLast_q     <= issueLast_q;
            outstanding_q <= outstanding_q + {1'b0, issue_d} - {1'b0, capValid_q};
            case (state_q)
                IDLE: begin
                    if (startAccept) begin
                        AB_q        <= start_addr;
                        addr_q      <= incAddr(start_addr);
                        remaining_q <= start_count - 1'b1;
                        state_q     <= (start_count == CountWidth'(1)) ? DRAIN : READ;
                    end
                end
                READ: begin
                    if (canIssue) begin
                        AB_q        <= addr_q;
                        addr_q      <= incAddr(addr_q);
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == CountWidth'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drainDone) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sram_read_fifo #(
        .DW(WIDTH + 1)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push_i     (capValid_q),
        .push_data_i({capLast_q, Q}),
        .pop_i      (pop),
        .head_o     (fifoHead),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount)
    );

    assign REB         = REB_q;
    assign AB          = AB_q;
    assign out_valid   = !fifoEmpty;
    assign out_data    = fifoHead[WIDTH-1:0];
    assign out_last    = fifoHead[WIDTH] && !fifoEmpty;
    assign busy        = (state_q != IDLE);
    assign start_ready = (state_q == IDLE);

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed and randomized checks of sram_stream_reader against a behavioural SRAM model.
module tb_sram_stream_reader;

    localparam int WIDTH = 128;
    localparam int NUM_ROWS = 4096;
    localparam int AW = 12;
    localparam int CW = 13;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [AW-1:0]    start_addr = '0;
    logic [CW-1:0]    start_count = '0;
    logic             REB;
    logic [AW-1:0]    AB;
    logic [WIDTH-1:0] Q = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    int tests = 0;
    int fails = 0;
    logic [WIDTH:0] popQ[$];
    logic [AW-1:0]  rebQ[$];

    sram_stream_reader #(
        .WIDTH(WIDTH),
        .NUM_ROWS(NUM_ROWS)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .start_addr (start_addr),
        .start_count(start_count),
        .REB        (REB),
        .AB         (AB),
        .Q          (Q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [WIDTH-1:0] rowData(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {20'hA5C3E, a};
        return {w ^ 32'h1111_1111, ~w, w + 32'd3, w};
    endfunction

    // SRAM read port: Q updates at the edge that samples REB low.
    always @(posedge CLK) begin
        if (!REB) Q <= rowData(AB);
    end

    // Handshakes and reads are logged mid-cycle, when every signal is stable.
    always @(negedge CLK) begin
        if (!RST) begin
            if (out_valid && out_ready) popQ.push_back({out_last, out_data});
            if (!REB) rebQ.push_back(AB);
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic startXfer(input logic [AW-1:0] a, input logic [CW-1:0] c);
        start_addr  = a;
        start_count = c;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input bit randReady, output bit timedOut);
        int c = 0;
        while (busy && c < budget) begin
            if (randReady) out_ready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        timedOut = busy;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        tests++;
        if ({REB, AB, out_valid, out_last, busy, start_ready} !== {1'b1, 12'd0, 4'b0001}) begin
            fails++;
            $display("[TB] FAIL reset_state got REB=%0b AB=%0d valid=%0b last=%0b busy=%0b ready=%0b want 1 0 0 0 0 1",
                     REB, AB, out_valid, out_last, busy, start_ready);
        end
    endtask

    task automatic test_basic();
        logic expReb;
        logic expValid;
        popQ.delete();
        rebQ.delete();
        out_ready = 1'b1;
        startXfer(12'd10, 13'd4);
        for (int k = 0; k <= 6; k++) begin
            expReb = (k < 4) ? 1'b0 : 1'b1;
            tests++;
            if (REB !== expReb || (!expReb && AB !== AW'(10 + k))) begin
                fails++;
                $display("[TB] FAIL basic_read k=%0d got REB=%0b AB=%0d want REB=%0b AB=%0d", k, REB, AB, expReb, 10 + k);
            end
            expValid = (k >= 2 && k <= 5);
            tests++;
            if (out_valid !== expValid ||
                (expValid && {out_last, out_data} !== {(k == 5), rowData(AW'(8 + k))})) begin
                fails++;
                $display("[TB] FAIL basic_out k=%0d got valid=%0b last=%0b data=%h want valid=%0b row %0d",
                         k, out_valid, out_last, out_data, expValid, 8 + k);
            end
            tests++;
            if (busy !== (k < 6) || start_ready !== (k >= 6)) begin
                fails++;
                $display("[TB] FAIL basic_busy k=%0d got busy=%0b ready=%0b want busy=%0b", k, busy, start_ready, k < 6);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        bit to;
        logic [AW-1:0] ea;
        popQ.delete();
        rebQ.delete();
        out_ready = 1'b1;
        startXfer(12'd4094, 13'd4);
        waitIdle(50, 1'b0, to);
        tests++;
        if (to || rebQ.size() != 4 || popQ.size() != 4) begin
            fails++;
            $display("[TB] FAIL wrap_sizes got timeout=%0b reads=%0d pops=%0d want 0 4 4", to, rebQ.size(), popQ.size());
        end
        for (int i = 0; i < 4 && i < rebQ.size() && i < popQ.size(); i++) begin
            ea = 12'd4094 + AW'(i);
            tests++;
            if (rebQ[i] !== ea || popQ[i] !== {(i == 3), rowData(ea)}) begin
                fails++;
                $display("[TB] FAIL wrap_row i=%0d got AB=%0d data=%h want AB=%0d", i, rebQ[i], popQ[i], ea);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        popQ.delete();
        rebQ.delete();
        out_ready = 1'b1;
        startXfer(12'd0, 13'd8);
        for (int c = 0; c < 20 && popQ.size() == 0; c++) tick();
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        tests++;
        if (rebQ.size() != 5 || REB !== 1'b1 || out_valid !== 1'b1 || popQ.size() != 1) begin
            fails++;
            $display("[TB] FAIL stall_credit got reads=%0d REB=%0b valid=%0b pops=%0d want 5 1 1 1",
                     rebQ.size(), REB, out_valid, popQ.size());
        end
        out_ready = 1'b1;
        waitIdle(50, 1'b0, to);
        tests++;
        if (to || rebQ.size() != 8 || popQ.size() != 8) begin
            fails++;
            $display("[TB] FAIL stall_sizes got timeout=%0b reads=%0d pops=%0d want 0 8 8", to, rebQ.size(), popQ.size());
        end
        for (int i = 0; i < 8 && i < rebQ.size() && i < popQ.size(); i++) begin
            tests++;
            if (rebQ[i] !== AW'(i) || popQ[i] !== {(i == 7), rowData(AW'(i))}) begin
                fails++;
                $display("[TB] FAIL stall_row i=%0d got AB=%0d data=%h want row %0d", i, rebQ[i], popQ[i], i);
            end
        end
    endtask

    task automatic test_zero_count();
        popQ.delete();
        rebQ.delete();
        out_ready = 1'b1;
        startXfer(12'd5, 13'd0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({REB, out_valid, start_ready, busy} !== 4'b1010) begin
                fails++;
                $display("[TB] FAIL zero_count k=%0d got REB=%0b valid=%0b ready=%0b busy=%0b want 1 0 1 0",
                         k, REB, out_valid, start_ready, busy);
            end
            tick();
        end
        tests++;
        if (rebQ.size() != 0 || popQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL zero_activity got reads=%0d pops=%0d want 0 0", rebQ.size(), popQ.size());
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        popQ.delete();
        rebQ.delete();
        out_ready = 1'b1;
        startXfer(12'd200, 13'd8);
        for (int c = 0; c < 20 && popQ.size() < 2; c++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tests++;
        if ({out_valid, REB, start_ready, busy} !== 4'b0110) begin
            fails++;
            $display("[TB] FAIL midreset_state got valid=%0b REB=%0b ready=%0b busy=%0b want 0 1 1 0",
                     out_valid, REB, start_ready, busy);
        end
        for (int c = 0; c < 3; c++) tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_stale got valid=%0b want 0", out_valid);
        end
        popQ.delete();
        rebQ.delete();
        startXfer(12'd100, 13'd2);
        waitIdle(50, 1'b0, to);
        tests++;
        if (to || popQ.size() != 2 || rebQ.size() != 2) begin
            fails++;
            $display("[TB] FAIL midreset_sizes got timeout=%0b pops=%0d reads=%0d want 0 2 2", to, popQ.size(), rebQ.size());
        end else begin
            tests++;
            if (popQ[0] !== {1'b0, rowData(12'd100)} || popQ[1] !== {1'b1, rowData(12'd101)} ||
                rebQ[0] !== 12'd100 || rebQ[1] !== 12'd101) begin
                fails++;
                $display("[TB] FAIL midreset_rows got %h %h AB %0d %0d want rows 100 101", popQ[0], popQ[1], rebQ[0], rebQ[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [WIDTH:0] want [4];
        popQ.delete();
        rebQ.delete();
        out_ready = 1'b0;
        startXfer(12'd300, 13'd3);
        tick();
        start_addr  = 12'd500;
        start_count = 13'd5;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        waitIdle(50, 1'b0, to);
        tests++;
        if (to || start_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_idle got timeout=%0b ready=%0b want 0 1", to, start_ready);
        end
        startXfer(12'd50, 13'd1);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_accept got busy=%0b want 1", busy);
        end
        waitIdle(50, 1'b0, to);
        want[0] = {1'b0, rowData(12'd300)};
        want[1] = {1'b0, rowData(12'd301)};
        want[2] = {1'b1, rowData(12'd302)};
        want[3] = {1'b1, rowData(12'd50)};
        tests++;
        if (to || popQ.size() != 4 || rebQ.size() != 4) begin
            fails++;
            $display("[TB] FAIL b2b_sizes got timeout=%0b pops=%0d reads=%0d want 0 4 4", to, popQ.size(), rebQ.size());
        end
        for (int i = 0; i < 4 && i < popQ.size(); i++) begin
            tests++;
            if (popQ[i] !== want[i]) begin
                fails++;
                $display("[TB] FAIL b2b_row i=%0d got %h want %h", i, popQ[i], want[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        bit ok;
        logic [AW-1:0] a;
        logic [CW-1:0] c;
        logic [AW-1:0] ea;
        for (int t = 0; t < 1000; t++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            a = AW'($urandom_range(0, NUM_ROWS - 1));
            c = CW'($urandom_range(0, 12));
            if (t == 500) begin
                a = 12'd4090;
                c = 13'd4100;
            end
            popQ.delete();
            rebQ.delete();
            startXfer(a, c);
            waitIdle(20000, 1'b1, to);
            ok = !to && popQ.size() == int'(c) && rebQ.size() == int'(c);
            for (int i = 0; ok && i < int'(c); i++) begin
                ea = a + AW'(i);
                if (popQ[i] !== {(i == int'(c) - 1), rowData(ea)} || rebQ[i] !== ea) ok = 1'b0;
            end
            tests++;
            if (!ok) begin
                fails++;
                $display("[TB] FAIL random_xfer t=%0d addr=%0d count=%0d got timeout=%0b pops=%0d reads=%0d",
                         t, a, c, to, popQ.size(), rebQ.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
